// File: rtl/integer_multiplier_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : integer_multiplier_arbiter_if
//  Purpose  : Bundles the requester-side and multiplier-side handshake
//             signals of integer_multiplier_arbiter.
//  Modports : slave  - arbiter side (drives grants, operands, results)
//             master - environment side (requesters plus the multiplier)
//  Ports    : requester bus  request_valid/signs/operands -> request_ack,
//                            result_valid/sign/result/exception <- result_ack
//             multiplier bus operand valids/signs/operands -> issue_ack,
//                            product_valid/sign/product/exception -> product_ack
//             status         busy, grant_id, protocol_error
//  Revision : 1.0  initial release
// ============================================================================
interface integer_multiplier_arbiter_if #(
  parameter int NUM_REQUESTERS        = 4,
  parameter int REQ_ID_WIDTH          = 2,
  parameter int OPERAND_WIDTH_IN_BITS = 64,
  parameter int PRODUCT_WIDTH_IN_BITS = 128
) ();
  // requester side
  logic [NUM_REQUESTERS-1:0]                       request_valid_in;
  logic [NUM_REQUESTERS-1:0]                       request_multiplicand_sign_in;
  logic [NUM_REQUESTERS-1:0]                       request_multiplier_sign_in;
  logic [NUM_REQUESTERS*OPERAND_WIDTH_IN_BITS-1:0] request_multiplicand_in;
  logic [NUM_REQUESTERS*OPERAND_WIDTH_IN_BITS-1:0] request_multiplier_in;
  logic [NUM_REQUESTERS-1:0]                       request_ack_out;
  logic [NUM_REQUESTERS-1:0]                       result_valid_out;
  logic                                            result_sign_out;
  logic [PRODUCT_WIDTH_IN_BITS-1:0]                result_out;
  logic                                            result_exception_out;
  logic [NUM_REQUESTERS-1:0]                       result_ack_in;
  // multiplier side
  logic                                            multiplicand_valid_out;
  logic                                            multiplier_valid_out;
  logic                                            multiplicand_sign_out;
  logic                                            multiplier_sign_out;
  logic [OPERAND_WIDTH_IN_BITS-1:0]                multiplicand_out;
  logic [OPERAND_WIDTH_IN_BITS-1:0]                multiplier_out;
  logic                                            issue_ack_in;
  logic                                            product_valid_in;
  logic                                            product_sign_in;
  logic [PRODUCT_WIDTH_IN_BITS-1:0]                product_in;
  logic                                            multiply_exception_in;
  logic                                            product_ack_out;
  // status
  logic                                            busy_out;
  logic [REQ_ID_WIDTH-1:0]                         grant_id_out;
  logic                                            protocol_error_out;

  modport slave (
    input  request_valid_in, request_multiplicand_sign_in, request_multiplier_sign_in,
    input  request_multiplicand_in, request_multiplier_in, result_ack_in,
    input  issue_ack_in, product_valid_in, product_sign_in, product_in, multiply_exception_in,
    output request_ack_out, result_valid_out, result_sign_out, result_out, result_exception_out,
    output multiplicand_valid_out, multiplier_valid_out, multiplicand_sign_out, multiplier_sign_out,
    output multiplicand_out, multiplier_out, product_ack_out,
    output busy_out, grant_id_out, protocol_error_out
  );

  modport master (
    output request_valid_in, request_multiplicand_sign_in, request_multiplier_sign_in,
    output request_multiplicand_in, request_multiplier_in, result_ack_in,
    output issue_ack_in, product_valid_in, product_sign_in, product_in, multiply_exception_in,
    input  request_ack_out, result_valid_out, result_sign_out, result_out, result_exception_out,
    input  multiplicand_valid_out, multiplier_valid_out, multiplicand_sign_out, multiplier_sign_out,
    input  multiplicand_out, multiplier_out, product_ack_out,
    input  busy_out, grant_id_out, protocol_error_out
  );
endinterface
`default_nettype wire

// File: rtl/integer_multiplier_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : integer_multiplier_arbiter
//  Purpose  : Round-robin sharing of one integer multiplier among
//             NUM_REQUESTERS clients, one operation outstanding at a time.
//             IDLE -> ISSUE -> EXECUTE -> DELIVER -> IDLE. All outputs are
//             registered.
//  Ports    : clk_in    clock, rising edge
//             reset_in  asynchronous active-low reset
//             arb_bus   requester, multiplier and status signals (slave side)
//  Revision : 1.0  initial release
// ============================================================================
module integer_multiplier_arbiter #(
  parameter int NUM_REQUESTERS        = 4,
  parameter int REQ_ID_WIDTH          = 2,
  parameter int OPERAND_WIDTH_IN_BITS = 64,
  parameter int PRODUCT_WIDTH_IN_BITS = 128
) (
  input  wire logic                     clk_in,
  input  wire logic                     reset_in,
  integer_multiplier_arbiter_if.slave   arb_bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_EXECUTE = 2'd2,
    ST_DELIVER = 2'd3
  } state_t;

  localparam logic [NUM_REQUESTERS-1:0] c_REQ_ONE = {{(NUM_REQUESTERS-1){1'b0}}, 1'b1};

  state_t                             r_state, w_state_next;
  logic [REQ_ID_WIDTH-1:0]            r_rr_ptr, w_rr_ptr_next;
  logic [REQ_ID_WIDTH-1:0]            r_owner, w_owner_next;
  logic                               r_op_valid, w_op_valid_next;
  logic                               r_mcand_sign, w_mcand_sign_next;
  logic                               r_mplier_sign, w_mplier_sign_next;
  logic [OPERAND_WIDTH_IN_BITS-1:0]   r_mcand, w_mcand_next;
  logic [OPERAND_WIDTH_IN_BITS-1:0]   r_mplier, w_mplier_next;
  logic [NUM_REQUESTERS-1:0]          r_request_ack, w_request_ack_next;
  logic [NUM_REQUESTERS-1:0]          r_result_valid, w_result_valid_next;
  logic                               r_result_sign, w_result_sign_next;
  logic [PRODUCT_WIDTH_IN_BITS-1:0]   r_result, w_result_next;
  logic                               r_result_exc, w_result_exc_next;
  logic                               r_product_ack, w_product_ack_next;
  logic                               r_busy, w_busy_next;
  logic                               r_protocol_error, w_protocol_error_next;

  logic                               w_grant_found;
  logic [REQ_ID_WIDTH-1:0]            w_grant_id;
  logic [REQ_ID_WIDTH-1:0]            w_idx;
  logic [NUM_REQUESTERS-1:0]          w_owner_onehot;

  // Round-robin search starting at pointer+1. The loop walks from the
  // farthest offset to the nearest so the nearest valid requester is the
  // last assignment and wins; offset N wraps onto the pointer itself.
  always_comb begin
    w_grant_found = 1'b0;
    w_grant_id    = r_rr_ptr;
    w_idx         = r_rr_ptr;
    for (int k = NUM_REQUESTERS; k >= 1; k--) begin
      w_idx = r_rr_ptr + REQ_ID_WIDTH'(k);
      if (arb_bus.request_valid_in[w_idx]) begin
        w_grant_found = 1'b1;
        w_grant_id    = w_idx;
      end
    end
  end

  assign w_owner_onehot = c_REQ_ONE << r_owner;

  always_comb begin
    w_state_next        = r_state;
    w_rr_ptr_next       = r_rr_ptr;
    w_owner_next        = r_owner;
    w_op_valid_next     = r_op_valid;
    w_mcand_sign_next   = r_mcand_sign;
    w_mplier_sign_next  = r_mplier_sign;
    w_mcand_next        = r_mcand;
    w_mplier_next       = r_mplier;
    w_request_ack_next  = '0;
    w_result_valid_next = r_result_valid;
    w_result_sign_next  = r_result_sign;
    w_result_next       = r_result;
    w_result_exc_next   = r_result_exc;
    w_product_ack_next  = 1'b0;
    // A product strobe is only legal while EXECUTE waits for it. The cycle
    // right after the capture is exempt: product_ack is still in flight
    // there and a multiplier that holds valid until it sees the ack is
    // behaving correctly.
    w_protocol_error_next = r_protocol_error |
                            (arb_bus.product_valid_in && (r_state != ST_EXECUTE) && !r_product_ack);

    case (r_state)
      ST_IDLE: begin
        if (w_grant_found) begin
          w_owner_next       = w_grant_id;
          w_mcand_next       = arb_bus.request_multiplicand_in[int'(w_grant_id) * OPERAND_WIDTH_IN_BITS +: OPERAND_WIDTH_IN_BITS];
          w_mplier_next      = arb_bus.request_multiplier_in[int'(w_grant_id) * OPERAND_WIDTH_IN_BITS +: OPERAND_WIDTH_IN_BITS];
          w_mcand_sign_next  = arb_bus.request_multiplicand_sign_in[w_grant_id];
          w_mplier_sign_next = arb_bus.request_multiplier_sign_in[w_grant_id];
          w_op_valid_next    = 1'b1;
          w_state_next       = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (arb_bus.issue_ack_in) begin
          w_op_valid_next    = 1'b0;
          w_request_ack_next = w_owner_onehot;
          w_state_next       = ST_EXECUTE;
        end
      end
      ST_EXECUTE: begin
        if (arb_bus.product_valid_in) begin
          w_result_next       = arb_bus.product_in;
          w_result_sign_next  = arb_bus.product_sign_in;
          w_result_exc_next   = arb_bus.multiply_exception_in;
          w_result_valid_next = w_owner_onehot;
          w_product_ack_next  = 1'b1;
          w_state_next        = ST_DELIVER;
        end
      end
      ST_DELIVER: begin
        // Acks from anyone but the owner are ignored.
        if (arb_bus.result_ack_in[r_owner]) begin
          w_result_valid_next = '0;
          w_rr_ptr_next       = r_owner;
          w_state_next        = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase

    w_busy_next = (w_state_next != ST_IDLE);
  end

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      r_state          <= ST_IDLE;
      r_rr_ptr         <= REQ_ID_WIDTH'(NUM_REQUESTERS - 1);
      r_owner          <= '0;
      r_op_valid       <= 1'b0;
      r_mcand_sign     <= 1'b0;
      r_mplier_sign    <= 1'b0;
      r_mcand          <= '0;
      r_mplier         <= '0;
      r_request_ack    <= '0;
      r_result_valid   <= '0;
      r_result_sign    <= 1'b0;
      r_result         <= '0;
      r_result_exc     <= 1'b0;
      r_product_ack    <= 1'b0;
      r_busy           <= 1'b0;
      r_protocol_error <= 1'b0;
    end else begin
      r_state          <= w_state_next;
      r_rr_ptr         <= w_rr_ptr_next;
      r_owner          <= w_owner_next;
      r_op_valid       <= w_op_valid_next;
      r_mcand_sign     <= w_mcand_sign_next;
      r_mplier_sign    <= w_mplier_sign_next;
      r_mcand          <= w_mcand_next;
      r_mplier         <= w_mplier_next;
      r_request_ack    <= w_request_ack_next;
      r_result_valid   <= w_result_valid_next;
      r_result_sign    <= w_result_sign_next;
      r_result         <= w_result_next;
      r_result_exc     <= w_result_exc_next;
      r_product_ack    <= w_product_ack_next;
      r_busy           <= w_busy_next;
      r_protocol_error <= w_protocol_error_next;
    end
  end

  assign arb_bus.request_ack_out        = r_request_ack;
  assign arb_bus.result_valid_out       = r_result_valid;
  assign arb_bus.result_sign_out        = r_result_sign;
  assign arb_bus.result_out             = r_result;
  assign arb_bus.result_exception_out   = r_result_exc;
  assign arb_bus.multiplicand_valid_out = r_op_valid;
  assign arb_bus.multiplier_valid_out   = r_op_valid;
  assign arb_bus.multiplicand_sign_out  = r_mcand_sign;
  assign arb_bus.multiplier_sign_out    = r_mplier_sign;
  assign arb_bus.multiplicand_out       = r_mcand;
  assign arb_bus.multiplier_out         = r_mplier;
  assign arb_bus.product_ack_out        = r_product_ack;
  assign arb_bus.busy_out               = r_busy;
  assign arb_bus.grant_id_out           = r_owner;
  assign arb_bus.protocol_error_out     = r_protocol_error;

endmodule
`default_nettype wire

// File: tb/tb_integer_multiplier_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_integer_multiplier_arbiter
//  Purpose  : Self-checking bench for integer_multiplier_arbiter. The bench
//             plays both the requesters and the shared multiplier; expected
//             grants come from a round-robin model over the request set and
//             expected products from plain arithmetic on requester operands.
//  Revision : 1.0  initial release
// ============================================================================
module tb_integer_multiplier_arbiter;
  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int OPW = 64;
  localparam int PRW = 128;

  logic clk_in;
  logic reset_in;
  int   n_tests;
  int   n_fail;

  integer_multiplier_arbiter_if #(.NUM_REQUESTERS(N), .REQ_ID_WIDTH(IDW),
    .OPERAND_WIDTH_IN_BITS(OPW), .PRODUCT_WIDTH_IN_BITS(PRW)) bus ();

  integer_multiplier_arbiter #(.NUM_REQUESTERS(N), .REQ_ID_WIDTH(IDW),
    .OPERAND_WIDTH_IN_BITS(OPW), .PRODUCT_WIDTH_IN_BITS(PRW)) dut (
    .clk_in  (clk_in),
    .reset_in(reset_in),
    .arb_bus (bus)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  // requester state and model state
  logic [OPW-1:0] op_a [N];
  logic [OPW-1:0] op_b [N];
  logic [N-1:0]   sa_v, sb_v, req_v;
  int             last_served;

  function automatic logic [PRW-1:0] ref_mul(input logic [OPW-1:0] a, input logic [OPW-1:0] b,
                                             input logic sa, input logic sb);
    logic [PRW-1:0] ea, eb;
    ea = sa ? {{OPW{a[OPW-1]}}, a} : {{OPW{1'b0}}, a};
    eb = sb ? {{OPW{b[OPW-1]}}, b} : {{OPW{1'b0}}, b};
    return ea * eb;
  endfunction

  // first pending requester after the last one served, wrapping around
  function automatic int rr_pick(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++) begin
      if (v[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int i);
    logic [N-1:0] r;
    r = '0;
    if (i >= 0 && i < N) r[i] = 1'b1;
    return r;
  endfunction

  function automatic logic [OPW-1:0] rand_operand();
    case ($urandom_range(0, 5))
      0:       return '1;
      1:       return {1'b1, {(OPW-1){1'b0}}};
      2:       return '0;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic drive_req();
    for (int i = 0; i < N; i++) begin
      bus.request_multiplicand_in[i*OPW +: OPW] = op_a[i];
      bus.request_multiplier_in[i*OPW +: OPW]   = op_b[i];
    end
    bus.request_multiplicand_sign_in = sa_v;
    bus.request_multiplier_sign_in   = sb_v;
    bus.request_valid_in             = req_v;
  endtask

  task automatic new_op(input int i);
    op_a[i] = rand_operand();
    op_b[i] = rand_operand();
    sa_v[i] = 1'($urandom_range(0, 1));
    sb_v[i] = 1'($urandom_range(0, 1));
  endtask

  task automatic apply_reset();
    reset_in = 1'b0;
    req_v = '0; sa_v = '0; sb_v = '0;
    for (int i = 0; i < N; i++) begin op_a[i] = '0; op_b[i] = '0; end
    drive_req();
    bus.result_ack_in = '0; bus.issue_ack_in = 1'b0; bus.product_valid_in = 1'b0;
    bus.product_sign_in = 1'b0; bus.product_in = '0; bus.multiply_exception_in = 1'b0;
    repeat (2) @(negedge clk_in);
    reset_in = 1'b1;
    last_served = N - 1;
    @(negedge clk_in);
  endtask

  // Acts as the multiplier for one operation. keep_req=1 keeps the owner's
  // request high and gives it fresh operands right after the grant (those
  // must not leak into the current operation); keep_req=0 drops it.
  task automatic serve(input bit keep_req, input int issue_dly, input int prod_dly, input bit exc,
                       output int gid, output logic [N-1:0] rack, output logic [N-1:0] rvalid,
                       output logic [PRW-1:0] res, output logic [PRW-1:0] expp,
                       output logic rsign, output logic rexc, output logic pack);
    logic [PRW-1:0] mprod;
    int n;
    gid = -1; rack = '0; rvalid = '0; res = '0; expp = '1; rsign = 1'b0; rexc = 1'b0; pack = 1'b0;
    n = 0;
    while (!bus.multiplicand_valid_out && n < 50) begin
      @(negedge clk_in);
      n++;
    end
    if (!bus.multiplicand_valid_out) return;
    gid   = int'(bus.grant_id_out);
    expp  = ref_mul(op_a[gid], op_b[gid], sa_v[gid], sb_v[gid]);
    mprod = ref_mul(bus.multiplicand_out, bus.multiplier_out,
                    bus.multiplicand_sign_out, bus.multiplier_sign_out);
    if (keep_req) begin new_op(gid); drive_req(); end
    repeat (issue_dly) @(negedge clk_in);
    bus.issue_ack_in = 1'b1;
    @(negedge clk_in);
    bus.issue_ack_in = 1'b0;
    rack = bus.request_ack_out;
    if (!keep_req) begin req_v[gid] = 1'b0; drive_req(); end
    repeat (prod_dly) @(negedge clk_in);
    bus.product_valid_in      = 1'b1;
    bus.product_in            = mprod;
    bus.product_sign_in       = mprod[PRW-1];
    bus.multiply_exception_in = exc;
    @(negedge clk_in);
    bus.product_valid_in = 1'b0;
    pack   = bus.product_ack_out;
    rvalid = bus.result_valid_out;
    res    = bus.result_out;
    rsign  = bus.result_sign_out;
    rexc   = bus.result_exception_out;
  endtask

  task automatic finish_op(input int gid, input int dly);
    if (gid < 0) return;
    repeat (dly) @(negedge clk_in);
    bus.result_ack_in = onehot(gid);
    @(negedge clk_in);
    bus.result_ack_in = '0;
    last_served = gid;
  endtask

  task automatic test_reset();
    apply_reset();
    n_tests++;
    if (bus.busy_out !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0b want 0", bus.busy_out); end
    n_tests++;
    if (bus.grant_id_out !== '0) begin n_fail++; $display("FAIL reset_grant got %0d want 0", bus.grant_id_out); end
    n_tests++;
    if ({bus.request_ack_out, bus.result_valid_out} !== '0) begin
      n_fail++; $display("FAIL reset_acks got %b want 0", {bus.request_ack_out, bus.result_valid_out}); end
    n_tests++;
    if ({bus.multiplicand_valid_out, bus.multiplier_valid_out, bus.product_ack_out, bus.protocol_error_out} !== 4'b0) begin
      n_fail++; $display("FAIL reset_ctrl got %b want 0000",
        {bus.multiplicand_valid_out, bus.multiplier_valid_out, bus.product_ack_out, bus.protocol_error_out}); end
    n_tests++;
    if (bus.result_out !== '0) begin n_fail++; $display("FAIL reset_result got %h want 0", bus.result_out); end
  endtask

  task automatic test_single();
    int gid; logic [N-1:0] rack, rvalid; logic [PRW-1:0] res, expp; logic rsign, rexc, pack;
    op_a[0] = 64'd3; op_b[0] = 64'd5; sa_v[0] = 1'b0; sb_v[0] = 1'b0;
    req_v = 4'b0001;
    drive_req();
    @(negedge clk_in);
    n_tests++;
    if ({bus.multiplicand_valid_out, bus.multiplier_valid_out, bus.busy_out} !== 3'b111) begin
      n_fail++; $display("FAIL single_latency got %b want 111",
        {bus.multiplicand_valid_out, bus.multiplier_valid_out, bus.busy_out}); end
    n_tests++;
    if ({bus.multiplicand_out, bus.multiplier_out} !== {64'd3, 64'd5}) begin
      n_fail++; $display("FAIL single_operands got %0d,%0d want 3,5", bus.multiplicand_out, bus.multiplier_out); end
    serve(1'b0, 1, 2, 1'b0, gid, rack, rvalid, res, expp, rsign, rexc, pack);
    n_tests++;
    if (rack !== 4'b0001) begin n_fail++; $display("FAIL single_req_ack got %b want 0001", rack); end
    n_tests++;
    if (rvalid !== 4'b0001) begin n_fail++; $display("FAIL single_valid got %b want 0001", rvalid); end
    n_tests++;
    if (res !== 128'd15) begin n_fail++; $display("FAIL single_result got %0d want 15", res); end
    n_tests++;
    if (pack !== 1'b1) begin n_fail++; $display("FAIL single_product_ack got %b want 1", pack); end
    finish_op(gid, 0);
    n_tests++;
    if ({bus.busy_out, bus.result_valid_out, bus.multiplicand_valid_out} !== '0) begin
      n_fail++; $display("FAIL single_done got %b want 0",
        {bus.busy_out, bus.result_valid_out, bus.multiplicand_valid_out}); end
  endtask

  task automatic test_round_robin();
    int gid, expg, prev; logic [N-1:0] rack, rvalid; logic [PRW-1:0] res, expp; logic rsign, rexc, pack;
    apply_reset();
    for (int i = 0; i < N; i++) new_op(i);
    req_v = '1;
    drive_req();
    prev = -1;
    for (int t = 0; t < 5; t++) begin
      expg = rr_pick(req_v, last_served);
      serve(1'b1, $urandom_range(0, 2), $urandom_range(0, 3), 1'b0, gid, rack, rvalid, res, expp, rsign, rexc, pack);
      n_tests++;
      if (gid !== expg || gid === prev) begin
        n_fail++; $display("FAIL rr_grant[%0d] got %0d want %0d (prev %0d)", t, gid, expg, prev); end
      n_tests++;
      if (rack !== onehot(expg) || rvalid !== onehot(expg) || res !== expp) begin
        n_fail++; $display("FAIL rr_result[%0d] got ack %b valid %b res %h want %b %h", t, rack, rvalid, res, onehot(expg), expp); end
      finish_op(gid, $urandom_range(0, 2));
      prev = gid;
    end
    req_v = '0;
    drive_req();
  endtask

  task automatic test_pending();
    int gid, expg; logic [N-1:0] rack, rvalid; logic [PRW-1:0] res, expp; logic rsign, rexc, pack;
    new_op(2);
    req_v = 4'b0100;
    drive_req();
    @(negedge clk_in);
    new_op(1); new_op(3);
    req_v = req_v | 4'b1010;
    drive_req();
    for (int t = 0; t < 3; t++) begin
      expg = rr_pick((t == 0) ? 4'b0100 : req_v, last_served);
      serve(1'b0, $urandom_range(0, 2), $urandom_range(0, 2), 1'b0, gid, rack, rvalid, res, expp, rsign, rexc, pack);
      n_tests++;
      if (gid !== expg || res !== expp) begin
        n_fail++; $display("FAIL pending_grant[%0d] got %0d res %h want %0d res %h", t, gid, res, expg, expp); end
      finish_op(gid, 0);
    end
  endtask

  task automatic test_delayed_ack();
    int r, s, gid, expg; logic [N-1:0] rack, rvalid; logic [PRW-1:0] res, expp; logic rsign, rexc, pack;
    r = $urandom_range(0, N-1);
    s = (r + 1 + $urandom_range(0, N-2)) % N;
    new_op(r); new_op(s);
    req_v = onehot(r) | onehot(s);
    drive_req();
    expg = rr_pick(req_v, last_served);
    serve(1'b0, 0, 1, 1'b0, gid, rack, rvalid, res, expp, rsign, rexc, pack);
    n_tests++;
    if (gid !== expg) begin n_fail++; $display("FAIL delay_grant got %0d want %0d", gid, expg); end
    for (int c = 0; c < 10; c++) begin
      bus.result_ack_in = ~onehot(gid);
      @(negedge clk_in);
      n_tests++;
      if (bus.result_out !== expp || bus.result_valid_out !== onehot(gid) || bus.busy_out !== 1'b1 ||
          bus.multiplicand_valid_out !== 1'b0) begin
        n_fail++; $display("FAIL delay_hold[%0d] got res %h valid %b busy %b issue %b want %h %b 1 0", c,
          bus.result_out, bus.result_valid_out, bus.busy_out, bus.multiplicand_valid_out, expp, onehot(gid)); end
    end
    bus.result_ack_in = '0;
    finish_op(gid, 0);
    expg = rr_pick(req_v, last_served);
    serve(1'b0, 1, 0, 1'b0, gid, rack, rvalid, res, expp, rsign, rexc, pack);
    n_tests++;
    if (gid !== expg || res !== expp) begin
      n_fail++; $display("FAIL delay_next got %0d res %h want %0d res %h", gid, res, expg, expp); end
    finish_op(gid, 0);
  endtask

  task automatic test_protocol_error();
    @(negedge clk_in);
    bus.product_valid_in = 1'b1;
    bus.product_in       = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk_in);
    bus.product_valid_in = 1'b0;
    n_tests++;
    if ({bus.product_ack_out, bus.protocol_error_out, bus.busy_out, bus.result_valid_out} !== {3'b010, 4'b0}) begin
      n_fail++; $display("FAIL perr_set got ack %b err %b busy %b valid %b want 0 1 0 0000",
        bus.product_ack_out, bus.protocol_error_out, bus.busy_out, bus.result_valid_out); end
    repeat (5) @(negedge clk_in);
    n_tests++;
    if (bus.protocol_error_out !== 1'b1) begin
      n_fail++; $display("FAIL perr_sticky got %b want 1", bus.protocol_error_out); end
  endtask

  task automatic test_reset_mid();
    int n, gid, expg; logic [N-1:0] rack, rvalid; logic [PRW-1:0] res, expp; logic rsign, rexc, pack;
    for (int i = 0; i < N; i++) new_op(i);
    req_v = '1;
    drive_req();
    n = 0;
    while (!bus.multiplicand_valid_out && n < 50) begin @(negedge clk_in); n++; end
    bus.issue_ack_in = 1'b1;
    @(negedge clk_in);
    bus.issue_ack_in = 1'b0;
    #2 reset_in = 1'b0;
    #1;
    n_tests++;
    if ({bus.busy_out, bus.request_ack_out, bus.grant_id_out, bus.multiplicand_valid_out, bus.multiplier_valid_out,
         bus.result_valid_out, bus.protocol_error_out, bus.product_ack_out} !== '0 || bus.result_out !== '0) begin
      n_fail++; $display("FAIL midreset_outputs got busy %b rack %b gid %0d valid %b rv %b perr %b want all 0",
        bus.busy_out, bus.request_ack_out, bus.grant_id_out, bus.multiplicand_valid_out,
        bus.result_valid_out, bus.protocol_error_out); end
    @(negedge clk_in);
    reset_in = 1'b1;
    last_served = N - 1;
    for (int t = 0; t < N; t++) begin
      expg = rr_pick(req_v, last_served);
      serve(1'b0, $urandom_range(0, 1), $urandom_range(0, 2), 1'b0, gid, rack, rvalid, res, expp, rsign, rexc, pack);
      n_tests++;
      if (gid !== expg || (t == 0 && gid !== 0) || res !== expp) begin
        n_fail++; $display("FAIL midreset_grant[%0d] got %0d res %h want %0d res %h", t, gid, res, expg, expp); end
      finish_op(gid, 0);
    end
  endtask

  task automatic test_random();
    int gid, expg; logic [N-1:0] rack, rvalid, add; logic [PRW-1:0] res, expp; logic rsign, rexc, pack; bit exc;
    for (int t = 0; t < 24; t++) begin
      add = N'($urandom_range(0, (1 << N) - 1));
      if ((req_v | add) == '0) add = onehot($urandom_range(0, N-1));
      for (int i = 0; i < N; i++) if (add[i] && !req_v[i]) new_op(i);
      req_v = req_v | add;
      drive_req();
      expg = rr_pick(req_v, last_served);
      exc  = 1'($urandom_range(0, 1));
      serve(1'b0, $urandom_range(0, 3), $urandom_range(0, 4), exc, gid, rack, rvalid, res, expp, rsign, rexc, pack);
      n_tests++;
      if (gid !== expg || rack !== onehot(expg) || rvalid !== onehot(expg) || pack !== 1'b1) begin
        n_fail++; $display("FAIL rand_grant[%0d] got %0d ack %b valid %b pack %b want %0d", t, gid, rack, rvalid, pack, expg); end
      n_tests++;
      if (res !== expp || rsign !== expp[PRW-1] || rexc !== exc) begin
        n_fail++; $display("FAIL rand_result[%0d] got %h s%b e%b want %h s%b e%b", t, res, rsign, rexc, expp, expp[PRW-1], exc); end
      finish_op(gid, $urandom_range(0, 3));
    end
    while (req_v != '0 && gid >= 0) begin
      expg = rr_pick(req_v, last_served);
      serve(1'b0, 0, 0, 1'b0, gid, rack, rvalid, res, expp, rsign, rexc, pack);
      n_tests++;
      if (gid !== expg || res !== expp) begin
        n_fail++; $display("FAIL drain_grant got %0d want %0d", gid, expg); end
      finish_op(gid, 0);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_pending();
    test_delayed_ack();
    test_protocol_error();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
